// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-port memory arbiter.
//   arb_state_t  : arbiter FSM encoding (IDLE / BUSY / RELEASE)
//   PORT_I/PORT_D: port indices (instruction cache / data cache)
//   addr_width() : block-address width from byte-address and block size
//   data_width() : block data width from word width and block size
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  function automatic int addr_width(input int address_size, input int block_size);
    return address_size - block_size - 2;
  endfunction

  function automatic int data_width(input int line_size, input int block_size);
    return (2 ** block_size) * line_size;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: saturating cycle counter that flags a hung transaction.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear (held while no transaction is in progress)
//   en     : count enable (one per BUSY cycle)
//   expire : high during the TIMEOUT_CYCLES-th enabled cycle after a clear
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt;

  // Saturates at TIMEOUT_CYCLES so a stuck enable can never wrap back to a
  // value that would fire expire a second time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (clr) begin
      wd_cnt <= '0;
    end else if (en && (wd_cnt != CNT_MAX)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign expire = en && (wd_cnt == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one block memory between the
// instruction cache (port 0) and the data cache (port 1). One whole
// transaction is granted at a time; a port that re-requests during the
// RELEASE cycle keeps the grant (eviction write-back followed by refill).
//   clk_i, reset_i          : clock, asynchronous active-low reset
//   p_read_i/p_wr_i[0:1]    : per-port block read / write request (level)
//   p_address_i[0:1]        : per-port block address
//   p_write_data_i[0:1]     : per-port write block
//   p_busywait_o[0:1]       : memory busy or port not granted
//   p_read_done_o/p_write_done_o[0:1] : completion pulses to the owner
//   p_read_data_o[0:1]      : read block to the owner
//   m_read_o, m_wr_o, m_address_o, m_write_data_o : memory request
//   m_busywait_i, m_read_done_i, m_write_done_i, m_read_data_i : memory status
//   err_o                   : one-cycle pulse when the watchdog aborts
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int c_line_size    = 32,
  parameter int c_block_size   = 2,
  parameter int address_size   = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ADDR_W = addr_width(address_size, c_block_size),
  localparam int DATA_W = data_width(c_line_size, c_block_size)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              p_read_i       [0:1],
  input  logic              p_wr_i         [0:1],
  input  logic [ADDR_W-1:0] p_address_i    [0:1],
  input  logic [DATA_W-1:0] p_write_data_i [0:1],
  output logic              p_busywait_o   [0:1],
  output logic              p_read_done_o  [0:1],
  output logic              p_write_done_o [0:1],
  output logic [DATA_W-1:0] p_read_data_o  [0:1],
  output logic              m_read_o,
  output logic              m_wr_o,
  output logic [ADDR_W-1:0] m_address_o,
  output logic [DATA_W-1:0] m_write_data_o,
  input  logic              m_busywait_i,
  input  logic              m_read_done_i,
  input  logic              m_write_done_i,
  input  logic [DATA_W-1:0] m_read_data_i,
  output logic              err_o
);

  arb_state_t state, state_nxt;
  logic       gnt, gnt_nxt;
  logic       last_gnt, last_gnt_nxt;
  logic       op_wr, op_wr_nxt;
  logic [1:0] req;
  logic       busy;
  logic       done_hit;
  logic       complete;
  logic       expire;
  logic       timeout;

  assign req[PORT_I] = p_read_i[PORT_I] | p_wr_i[PORT_I];
  assign req[PORT_D] = p_read_i[PORT_D] | p_wr_i[PORT_D];

  assign busy     = (state == BUSY);
  assign done_hit = op_wr ? m_write_done_i : m_read_done_i;
  assign complete = busy && !m_busywait_i && done_hit;
  // A real completion in the expiry cycle wins over the abort.
  assign timeout  = expire && !complete;

  // Held in clear outside BUSY, so every entry into BUSY starts from zero.
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk_i),
    .rst_n (reset_i),
    .clr   (!busy),
    .en    (busy),
    .expire(expire)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      op_wr    <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
      op_wr    <= op_wr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    op_wr_nxt    = op_wr;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_nxt   = (req == 2'b11) ? ~last_gnt : req[PORT_D];
          // A simultaneous read and write is treated as a write.
          op_wr_nxt = p_wr_i[gnt_nxt];
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (complete) begin
          last_gnt_nxt = gnt;
          state_nxt    = RELEASE;
        end else if (timeout) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // Owner re-requesting keeps the grant: write-back then refill.
        if (req[gnt]) begin
          op_wr_nxt = p_wr_i[gnt];
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    m_read_o       = 1'b0;
    m_wr_o         = 1'b0;
    m_address_o    = '0;
    m_write_data_o = '0;
    err_o          = 1'b0;
    for (int p = 0; p < 2; p++) begin
      // Masked by reset so every output reads 0 while reset is held.
      p_busywait_o[p]   = reset_i & req[p];
      p_read_done_o[p]  = 1'b0;
      p_write_done_o[p] = 1'b0;
      p_read_data_o[p]  = '0;
    end
    if (busy) begin
      m_read_o       = !op_wr && req[gnt] && !complete && !timeout;
      m_wr_o         =  op_wr && req[gnt] && !complete && !timeout;
      m_address_o    = p_address_i[gnt];
      m_write_data_o = p_write_data_i[gnt];
      if (timeout) begin
        p_busywait_o[gnt]   = 1'b0;
        p_read_done_o[gnt]  = !op_wr;
        p_write_done_o[gnt] = op_wr;
        err_o               = 1'b1;
      end else begin
        p_busywait_o[gnt]   = m_busywait_i;
        p_read_done_o[gnt]  = m_read_done_i;
        p_write_done_o[gnt] = m_write_done_i;
        p_read_data_o[gnt]  = m_read_data_i;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares one block-wide data memory between two cache instances (port 0 = instruction cache, port 1 = data cache). It sits between the caches' memory-side interfaces and the memory. It grants one whole transaction at a time and routes done/busywait back to the owner only. A grant is held across an eviction write-back followed by its refill read, and a watchdog aborts hung transactions.

## Interface
- `c_line_size`, 32, word width in bits
- `c_block_size`, 2, log2 words per block; DATA_W = 2**c_block_size*c_line_size (128)
- `address_size`, 32, byte address width; ADDR_W = address_size-c_block_size-2 (28)
- `TIMEOUT_CYCLES`, 255, maximum BUSY cycles before abort
- `clk_i` in 1: single clock, all state on rising edge
- `reset_i` in 1: asynchronous, active-low reset
- `p_read_i[0:1]` in 1 each: port block-read request (level, held until done)
- `p_wr_i[0:1]` in 1 each: port block-write request
- `p_address_i[0:1]` in ADDR_W each: block address
- `p_write_data_i[0:1]` in DATA_W each: write block
- `p_busywait_o[0:1]` out 1 each: memory busy / port not granted
- `p_read_done_o[0:1]`, `p_write_done_o[0:1]` out 1 each: completion pulses
- `p_read_data_o[0:1]` out DATA_W each: read block
- `m_read_o`, `m_wr_o` out 1: memory command
- `m_address_o` out ADDR_W, `m_write_data_o` out DATA_W: memory request
- `m_busywait_i`, `m_read_done_i`, `m_write_done_i` in 1: memory status
- `m_read_data_i` in DATA_W: memory read block
- `err_o` out 1: one-cycle pulse on watchdog abort

## Operation
- Request of port p: `p_read_i[p] | p_wr_i[p]`. If both are high, the request is a write.
- FSM states: IDLE, BUSY, RELEASE. Registers: `gnt` (1 bit), `last_gnt` (1 bit), `op_wr` (1 bit), watchdog count `wd_cnt`.
- IDLE: with one port requesting, grant that port. With both requesting, grant `!last_gnt`. At the edge, latch `gnt` and `op_wr` and go to BUSY. No request: stay in IDLE.
- BUSY: `m_read_o`/`m_wr_o` = latched op, qualified by the granted port still requesting. `m_address_o`/`m_write_data_o` = granted port's inputs. The granted port receives `m_busywait_i`, done and read data directly.
- Completion: `!m_busywait_i && m_read_done_i` for a read, or `!m_busywait_i && m_write_done_i` for a write. On completion, drive that command low, set `last_gnt <= gnt` and go to RELEASE.
- RELEASE (one cycle): memory commands are 0.
  - If the granted port requests again, return to BUSY for the same port without arbitration and re-latch `op_wr`. This is the write-back → refill lock.
  - Otherwise go to IDLE.
- Non-granted or idle port: `p_busywait_o` = 1 while requesting, else 0. Its done outputs are 0 and its `p_read_data_o` is 0.
- Watchdog: `wd_cnt` clears on entry to BUSY and increments each BUSY cycle. When `wd_cnt == TIMEOUT_CYCLES-1` without completion, the block:
  - pulses the granted port's matching done with `p_busywait_o`=0 and `p_read_data_o`=0,
  - pulses `err_o`,
  - goes to RELEASE.
- `wd_cnt` width is $clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.

## Timing
- Reset (`reset_i`=0, any time including mid-transaction): state IDLE, `gnt`=0, `last_gnt`=1 (port 0 wins the first tie), `op_wr`=0, `wd_cnt`=0. All outputs are 0: `m_read_o`, `m_wr_o`, `m_address_o`, `m_write_data_o`, every `p_*_o`, `err_o`. A memory transaction in flight is dropped.
- Grant latency: request seen in IDLE at edge N → `m_read_o`/`m_wr_o` high in cycle N+1.
- Done/busywait/read data reach the owner combinationally in the same cycle as the memory.
- A lone port with back-to-back write→read loses no cycles beyond the RELEASE cycle.
- A competing port waits at most one full transaction pair plus RELEASE and IDLE (2 cycles).
- Simultaneous new request and completion: the new request is ignored until IDLE or RELEASE.
- Granted port dropping its request mid-BUSY: the memory command drops. The state stays BUSY until completion or timeout.

## Structure
- Package `mem_arb_pkg`: state encoding (IDLE=2'b00, BUSY=2'b01, RELEASE=2'b10), port constants `PORT_I`=0, `PORT_D`=1, and the width functions for ADDR_W and DATA_W.
- Sub-module `mem_arb_watchdog`: counter with clear, enable and expire output, parameterised by TIMEOUT_CYCLES.
- Arbitration and muxing stay in `mem_arbiter`.

## Test plan
- Single read: port 0 reads address 28'h0000010, memory completes after 4 cycles with `m_read_data_i`=128'hA5…A5 → `p_read_done_o[0]` pulses once with that data; `p_busywait_o[1]`=0 throughout.
- Tie: both ports read in the same cycle after reset → port 0 is served first, then port 1. The next tie grants port 0 again (`last_gnt`=1).
- Eviction lock: port 1 writes 28'h0000020, then asserts read 28'h0000040 in RELEASE while port 0 is requesting → port 1's read is granted before port 0. Port 0 sees busywait=1 until IDLE.
- Timeout: TIMEOUT_CYCLES=8, memory never signals done → `err_o` and `p_read_done_o[p]` pulse in the 8th BUSY cycle, read data is 0, FSM returns to IDLE.
- Reset mid-BUSY: assert `reset_i`=0 for 1 cycle during a write → all outputs are 0 immediately. After release, a fresh request is granted with 1-cycle latency.
- Read+write both high on port 0 → the memory sees `m_wr_o`=1 and `m_read_o`=0.
